// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage SRAM interface.
package mem_stage_pkg;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int          SRAM_DW       = 16;
  localparam int          WORD_W        = 32;
  localparam int          CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// Two-half-access SRAM sequencer: FSM, hold counter, DQ tristate and load capture.
// Optional MEM_ADDR_CHECK_EN adds a per-access error latch that suppresses the SRAM effect.
//
//   state | meaning
//   IDLE  | waiting; a request here is accepted on the next edge
//   RD_LO | drive low half-word address, capture DQ into [15:0] on the last cycle
//   RD_HI | drive high half-word address, capture DQ into [31:16] on the last cycle
//   WR_LO | drive low half-word address and store data [15:0], WE_N low
//   WR_HI | drive high half-word address and store data [31:16], WE_N low
//   DONE  | one-cycle completion, ready high, never starts a new access
module sram_controller
  import mem_stage_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic                wr_req,
`ifdef MEM_ADDR_CHECK_EN
  input  logic                addr_err,
  output logic                addr_err_flag,
`endif
  input  logic [WORD_W-1:0]   wr_data,
  output logic [WORD_W-1:0]   rd_data,
  output logic                ready,
  output logic                addr_en,
  output logic                addr_half,
  output logic                sram_we_n,
  inout  wire  [SRAM_DW-1:0]  sram_dq
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               term;
  logic               timed;
  logic               accept;
  logic               acc_err;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;

  assign term   = (cnt == LAST);
  assign timed  = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);
  assign accept = (state == IDLE) && (rd_req || wr_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (!timed || (state_nxt != state))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      // an erroneous read still runs its timing but loads zero
      if ((state == RD_LO) && term)
        rd_data[15:0] <= acc_err ? '0 : sram_dq;
      if ((state == RD_HI) && term)
        rd_data[31:16] <= acc_err ? '0 : sram_dq;
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_err       <= 1'b0;
      addr_err_flag <= 1'b0;
    end else if (accept) begin
      acc_err <= addr_err;
      if (addr_err)
        addr_err_flag <= 1'b1;
    end
  end
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = !(rd_req || wr_req);
        if (wr_req)
          state_nxt = WR_LO;
        else if (rd_req)
          state_nxt = RD_LO;
      end
      RD_LO: if (term) state_nxt = RD_HI;
      RD_HI: if (term) state_nxt = DONE;
      WR_LO: if (term) state_nxt = WR_HI;
      WR_HI: if (term) state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bus outputs are gated by rst so the SRAM sees an idle bus during the reset cycle
  assign addr_en   = timed && !rst;
  assign addr_half = (state == RD_HI) || (state == WR_HI);
  assign dq_oe     = ((state == WR_LO) || (state == WR_HI)) && !rst && !acc_err;
  assign dq_out    = (state == WR_HI) ? wr_data[31:16] : wr_data[15:0];
  assign sram_we_n = !dq_oe;
  assign sram_dq   = dq_oe ? dq_out : {SRAM_DW{1'bz}};

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage backed by a 16-bit asynchronous SRAM; pass-throughs and address mapping.
// Define MEM_ADDR_CHECK_EN to add the sticky addrErrOut port and suppress erroneous accesses.
module mem_stage_sram
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          SRAM_AW       = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                WB_ENIn,
  input  logic                MEM_R_ENIn,
  input  logic                MEM_W_ENIn,
  input  logic [31:0]         ALU_ResIn,
  input  logic [31:0]         Val_RmIn,
  input  logic [3:0]          DestIn,
  output logic                WB_ENOut,
  output logic                MEM_R_ENOut,
  output logic [31:0]         ALU_ResOut,
  output logic [3:0]          DestOut,
  output logic [31:0]         memReadValueOut,
  output logic                readyOut,
`ifdef MEM_ADDR_CHECK_EN
  output logic                addrErrOut,
`endif
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  inout  wire  [15:0]         SRAM_DQ,
  output logic                SRAM_WE_N
);

  logic [SRAM_AW-2:0] word_idx;
  logic               addr_en;
  logic               addr_half;

  assign WB_ENOut    = WB_ENIn;
  assign MEM_R_ENOut = MEM_R_ENIn;
  assign ALU_ResOut  = ALU_ResIn;
  assign DestOut     = DestIn;

  // byte offset to 32-bit word index; the cast drops bits above the SRAM range
  assign word_idx  = (SRAM_AW - 1)'((ALU_ResIn - BASE_ADDR) >> 2);
  assign SRAM_ADDR = addr_en ? {word_idx, addr_half} : '0;

`ifdef MEM_ADDR_CHECK_EN
  logic addr_err;

  assign addr_err = (ALU_ResIn < BASE_ADDR) ||
                    (ALU_ResIn[1:0] != 2'b00) ||
                    (((ALU_ResIn - BASE_ADDR) >> (SRAM_AW + 1)) != 32'd0);
`endif

  sram_controller #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .rd_req        (MEM_R_ENIn),
    .wr_req        (MEM_W_ENIn),
`ifdef MEM_ADDR_CHECK_EN
    .addr_err      (addr_err),
    .addr_err_flag (addrErrOut),
`endif
    .wr_data       (Val_RmIn),
    .rd_data       (memReadValueOut),
    .ready         (readyOut),
    .addr_en       (addr_en),
    .addr_half     (addr_half),
    .sram_we_n     (SRAM_WE_N),
    .sram_dq       (SRAM_DQ)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a small behavioural SRAM on the DQ bus.
module tb_mem_stage_sram;

  localparam int AC = 2;
  localparam int NACC = 2 * AC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en, r_en, w_en;
  logic [31:0] alu, val;
  logic [3:0]  dest;
  logic        wb_out, r_out;
  logic [31:0] alu_out, rd_val;
  logic [3:0]  dest_out;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
`ifdef MEM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  logic [15:0] mem [0:63];
  logic        mem_init;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(i * 16'h0101) ^ 16'hA5C3;
    end else if (!sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  assign sram_dq = sram_we_n ? mem[sram_addr[5:0]] : 16'hzzzz;

  mem_stage_sram #(
    .BASE_ADDR     (1024),
    .ACCESS_CYCLES (AC),
    .SRAM_AW       (18)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .WB_ENIn         (wb_en),
    .MEM_R_ENIn      (r_en),
    .MEM_W_ENIn      (w_en),
    .ALU_ResIn       (alu),
    .Val_RmIn        (val),
    .DestIn          (dest),
    .WB_ENOut        (wb_out),
    .MEM_R_ENOut     (r_out),
    .ALU_ResOut      (alu_out),
    .DestOut         (dest_out),
    .memReadValueOut (rd_val),
    .readyOut        (ready),
`ifdef MEM_ADDR_CHECK_EN
    .addrErrOut      (addr_err),
`endif
    .SRAM_ADDR       (sram_addr),
    .SRAM_DQ         (sram_dq),
    .SRAM_WE_N       (sram_we_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 1'b0; r_en = 1'b0; w_en = 1'b0;
    alu = '0; val = '0; dest = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    idle_inputs();
    tick(); tick();
    mem_init = 1'b0;
    #1;
    vectors++;
    if ({ready, sram_we_n, sram_addr, rd_val} !== {1'b1, 1'b1, 18'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_hold: got rdy/we_n/addr/rd=%b/%b/%0d/%h want 1/1/0/0", ready, sram_we_n, sram_addr, rd_val);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({ready, sram_we_n, sram_addr, rd_val, sram_dq} !== {1'b1, 1'b1, 18'd0, 32'd0, 16'hA5C3}) begin
      errors++;
      $display("FAIL reset_after: got rdy/we_n/addr/rd/dq=%b/%b/%0d/%h/%h want 1/1/0/0/a5c3", ready, sram_we_n, sram_addr, rd_val, sram_dq);
    end
  endtask

  task automatic test_nonmem();
    wb_en = 1'b1; alu = 32'h55; dest = 4'd3;
    #1;
    vectors++;
    if ({ready, wb_out, r_out, alu_out, dest_out} !== {1'b1, 1'b1, 1'b0, 32'h55, 4'd3}) begin
      errors++;
      $display("FAIL nonmem_pass: got rdy/wb/r/alu/dest=%b/%b/%b/%h/%0d want 1/1/0/55/3", ready, wb_out, r_out, alu_out, dest_out);
    end
    vectors++;
    if ({sram_we_n, sram_dq} !== {1'b1, 16'hA5C3}) begin
      errors++;
      $display("FAIL nonmem_bus: got we_n/dq=%b/%h want 1/a5c3", sram_we_n, sram_dq);
    end
    tick();
    vectors++;
    if ({ready, sram_addr} !== {1'b1, 18'd0}) begin
      errors++;
      $display("FAIL nonmem_stay: got rdy/addr=%b/%0d want 1/0", ready, sram_addr);
    end
    idle_inputs();
  endtask

  task automatic test_store();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    int          words [3];
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    addrs = '{32'd1032, 32'd1024, 32'd5024};
    datas = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADCAFE};
    words = '{2, 0, 1000};
    for (int v = 0; v < 3; v++) begin
      w_en = 1'b1; alu = addrs[v]; val = datas[v];
      #1;
      vectors++;
      if ({ready, sram_we_n, sram_addr} !== {1'b0, 1'b1, 18'd0}) begin
        errors++;
        $display("FAIL store_accept[%0d]: got rdy/we_n/addr=%b/%b/%0d want 0/1/0", v, ready, sram_we_n, sram_addr);
      end
      for (int c = 1; c <= 2 * AC; c++) begin
        tick();
        exp_addr = 18'(words[v] * 2 + ((c > AC) ? 1 : 0));
        exp_dq   = (c > AC) ? datas[v][31:16] : datas[v][15:0];
        vectors++;
        if ({ready, sram_we_n, sram_addr, sram_dq} !== {1'b0, 1'b0, exp_addr, exp_dq}) begin
          errors++;
          $display("FAIL store_cyc[%0d.%0d]: got rdy/we_n/addr/dq=%b/%b/%0d/%h want 0/0/%0d/%h",
                   v, c, ready, sram_we_n, sram_addr, sram_dq, exp_addr, exp_dq);
        end
      end
      tick();
      vectors++;
      if ({ready, sram_we_n, sram_addr} !== {1'b1, 1'b1, 18'd0}) begin
        errors++;
        $display("FAIL store_done[%0d]: got rdy/we_n/addr=%b/%b/%0d want 1/1/0", v, ready, sram_we_n, sram_addr);
      end
      idle_inputs();
      tick();
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input string name);
    int n_low;
    bit done;
    n_low = 0; done = 1'b0;
    r_en = 1'b1; alu = a;
    #1;
    for (int c = 0; c < 4 * AC + 4 && !done; c++) begin
      if (ready === 1'b1) begin
        done = 1'b1;
      end else begin
        n_low++;
        vectors++;
        if (sram_we_n !== 1'b1) begin
          errors++;
          $display("FAIL %s_we_n: got %b want 1 at low cycle %0d", name, sram_we_n, n_low);
        end
        tick();
      end
    end
    vectors++;
    if (!done || n_low != 2 * AC + 1) begin
      errors++;
      $display("FAIL %s_ready_low: got %0d cycles (done=%0d) want %0d", name, n_low, done, 2 * AC + 1);
    end
    vectors++;
    if (rd_val !== exp) begin
      errors++;
      $display("FAIL %s_data: got %h want %h", name, rd_val, exp);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load();
    do_load(32'd1032, 32'hDEADBEEF, "load_1032");
    do_load(32'd1024, 32'hCAFEF00D, "load_1024");
    do_load(32'd5024, 32'h0BADCAFE, "load_5024");
  endtask

  task automatic test_reset_mid();
    r_en = 1'b1; alu = 32'd1032;
    #1;
    for (int c = 0; c <= AC; c++) tick();
    vectors++;
    if (sram_addr !== 18'd5) begin
      errors++;
      $display("FAIL rstmid_in_rd_hi: got addr %0d want 5", sram_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({sram_we_n, sram_addr} !== {1'b1, 18'd0}) begin
      errors++;
      $display("FAIL rstmid_during: got we_n/addr=%b/%0d want 1/0", sram_we_n, sram_addr);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if ({ready, rd_val, sram_we_n, sram_addr} !== {1'b1, 32'd0, 1'b1, 18'd0}) begin
      errors++;
      $display("FAIL rstmid_after: got rdy/rd/we_n/addr=%b/%h/%b/%0d want 1/0/1/0", ready, rd_val, sram_we_n, sram_addr);
    end
    tick();
  endtask

  task automatic test_both_enables();
    logic exp_we_n;
    do_load(32'd1024, 32'hCAFEF00D, "both_preload");
    r_en = 1'b1; w_en = 1'b1; alu = 32'd1036; val = 32'h12345678;
    #1;
    for (int c = 0; c < NACC; c++) begin
      exp_we_n = !(c >= 1 && c <= 2 * AC);
      vectors++;
      if ({sram_we_n, rd_val} !== {exp_we_n, 32'hCAFEF00D}) begin
        errors++;
        $display("FAIL both_cyc[%0d]: got we_n/rd=%b/%h want %b/cafef00d", c, sram_we_n, rd_val, exp_we_n);
      end
      if (c == NACC - 1) idle_inputs();
      tick();
    end
    do_load(32'd1036, 32'h12345678, "both_readback");
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    r_en = 1'b1; alu = 32'd1032;
    #1;
    for (int c = 0; c < 2 * NACC; c++) begin
      exp_rdy = ((c % NACC) == NACC - 1);
      vectors++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", c, ready, exp_rdy);
      end
      if (c == 2 * NACC - 1) idle_inputs();
      tick();
    end
    vectors++;
    if ({ready, rd_val} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL b2b_end: got rdy/rd=%b/%h want 1/deadbeef", ready, rd_val);
    end
  endtask

`ifdef MEM_ADDR_CHECK_EN
  task automatic test_addr_check();
    logic exp_rdy;
    w_en = 1'b1; alu = 32'd1026; val = 32'h11112222;
    #1;
    vectors++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL addrchk_before: got %b want 0", addr_err);
    end
    for (int c = 0; c < NACC; c++) begin
      exp_rdy = (c == NACC - 1);
      vectors++;
      if ({ready, sram_we_n} !== {exp_rdy, 1'b1}) begin
        errors++;
        $display("FAIL addrchk_cyc[%0d]: got rdy/we_n=%b/%b want %b/1", c, ready, sram_we_n, exp_rdy);
      end
      if (c >= 1) begin
        vectors++;
        if (addr_err !== 1'b1) begin
          errors++;
          $display("FAIL addrchk_flag[%0d]: got %b want 1", c, addr_err);
        end
      end
      if (c == NACC - 1) idle_inputs();
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b0;
    idle_inputs();
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_reset_mid();
    test_both_enables();
    test_back_to_back();
`ifdef MEM_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
